// File: rtl/spi_div_slave.sv
// SPI responder computing unsigned WIDTH-bit quotient or remainder with a restoring divider.
// Optional build macro SPI_DIV_FAST_EXIT_EN: skip the divider loop when opb == 0 or opa < opb.
module spi_div_slave #(
  parameter int              WIDTH  = 16,
  parameter int              OP_W   = 3,
  parameter logic [OP_W-1:0] OP_DIV = 3'b110,
  parameter logic [OP_W-1:0] OP_REM = 3'b111
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_nss,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy,
  output logic o_abort
);

  localparam int FRAME_W = 2 * WIDTH + OP_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_RX  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_TX  = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_CALC,
    S_RESP_START,
    S_RESP
  } state_t;

  state_t              state, state_nxt;
  logic                abort_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [FRAME_W-1:0]  sr;
  logic [WIDTH:0]      rem;
  logic [WIDTH-1:0]    res;

  logic [OP_W-1:0]     op;
  logic [WIDTH-1:0]    opb;
  logic [WIDTH-1:0]    quo_field;
  logic [WIDTH+1:0]    shifted;
  logic [WIDTH+1:0]    diff;
  logic                ge;

  function automatic logic [WIDTH-1:0] select_result(input logic [OP_W-1:0]  sel_op,
                                                     input logic [WIDTH-1:0] quo,
                                                     input logic [WIDTH-1:0] rmd);
    if (sel_op == OP_DIV)      return quo;
    else if (sel_op == OP_REM) return rmd;
    else                       return '0;
  endfunction

  // The dividend field of the request register doubles as the quotient register.
  assign op        = sr[OP_W-1:0];
  assign opb       = sr[OP_W +: WIDTH];
  assign quo_field = sr[FRAME_W-1 -: WIDTH];

  // rem < opb always holds, so a negative trial difference shows up in the top bit.
  assign shifted = {rem, quo_field[WIDTH-1]};
  assign diff    = shifted - {2'b00, opb};
  assign ge      = ~diff[WIDTH+1];

`ifdef SPI_DIV_FAST_EXIT_EN
  logic fast_exit;
  assign fast_exit = (opb == '0) || (quo_field < opb);
`endif

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    abort_nxt = 1'b0;
    o_miso    = 1'b1;
    case (state)
      S_IDLE: begin
        o_miso = i_nss;
        if (!i_nss && i_mosi) state_nxt = S_RECV;
      end
      S_RECV: begin
        o_miso = 1'b0;
        if (cnt == LAST_RX) state_nxt = S_CALC;
      end
      S_CALC: begin
        o_miso = 1'b0;
        if (cnt == CNT_DONE) state_nxt = S_RESP_START;
      end
      S_RESP_START: begin
        o_miso    = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        o_miso = res[0];
        if (cnt == LAST_TX) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Deselect on the final response bit counts as a clean finish, not an abort.
    if ((state != S_IDLE) && i_nss && !((state == S_RESP) && (cnt == LAST_TX))) begin
      state_nxt = S_IDLE;
      abort_nxt = 1'b1;
    end
    if (!i_reset) o_miso = 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt     <= '0;
      sr      <= '0;
      rem     <= '0;
      res     <= '0;
      o_abort <= 1'b0;
    end else begin
      o_abort <= abort_nxt;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          rem <= '0;
        end
        S_RECV: begin
          sr  <= {i_mosi, sr[FRAME_W-1:1]};
          cnt <= (cnt == LAST_RX) ? '0 : cnt + 1'b1;
        end
        S_CALC: begin
          if (cnt == CNT_DONE) begin
            res <= select_result(op, quo_field, rem[WIDTH-1:0]);
          end
`ifdef SPI_DIV_FAST_EXIT_EN
          else if ((cnt == '0) && fast_exit) begin
            rem                    <= {1'b0, quo_field};
            sr[FRAME_W-1 -: WIDTH] <= (opb == '0) ? '1 : '0;
            cnt                    <= CNT_DONE;
          end
`endif
          else begin
            rem                    <= ge ? diff[WIDTH:0] : shifted[WIDTH:0];
            sr[FRAME_W-1 -: WIDTH] <= {quo_field[WIDTH-2:0], ge};
            cnt                    <= cnt + 1'b1;
          end
        end
        S_RESP_START: cnt <= '0;
        S_RESP: begin
          res <= res >> 1;
          cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_div_slave.sv
// Directed bench for spi_div_slave: framed requests, serial result capture, abort and reset cases.
module tb_spi_div_slave;

  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_REM = 3'b111;
  localparam int STD_START = 52;
`ifdef SPI_DIV_FAST_EXIT_EN
  localparam int FAST_START = 37;
`else
  localparam int FAST_START = 52;
`endif

  logic i_clock = 1'b0;
  logic i_reset = 1'b0;
  logic i_nss   = 1'b1;
  logic i_mosi  = 1'b0;
  logic o_miso, o_busy, o_abort;

  int checks = 0;
  int errors = 0;
  int e      = 0;
  int ones;
  logic [34:0] vec;

  spi_div_slave dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_nss   (i_nss),
    .i_mosi  (i_mosi),
    .o_miso  (o_miso),
    .o_busy  (o_busy),
    .o_abort (o_abort)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then park on the falling edge where outputs are sampled and inputs change.
  task automatic step();
    @(posedge i_clock);
    e++;
    @(negedge i_clock);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] opa, input logic [15:0] opb,
                           input logic [2:0] op, input logic [15:0] exp_res,
                           input int exp_start, input bit nss_last);
    logic [34:0] v;
    logic [15:0] got;
    v = {opa, opb, op};
    i_mosi = 1'b1;
    e = -1;
    step();
    chk({tag, " busy_rx"}, o_busy, 1);
    for (int i = 0; i < 35; i++) begin
      i_mosi = v[i];
      step();
    end
    chk({tag, " miso_calc"}, o_miso, 0);
    i_mosi = 1'b1;
    while (o_miso !== 1'b1 && e < 100) step();
    chk({tag, " start_cycle"}, e, exp_start);
    i_mosi = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      got[k] = o_miso;
      if (k == 15 && nss_last) i_nss = 1'b1;
    end
    chk({tag, " result"}, got, exp_res);
    step();
    chk({tag, " busy_end"}, o_busy, 0);
    chk({tag, " end_cycle"}, e, exp_start + 17);
    chk({tag, " no_abort"}, o_abort, 0);
  endtask

  initial begin
    repeat (2) @(negedge i_clock);
    chk("rst_miso", o_miso, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_abort", o_abort, 0);
    i_reset = 1'b1;
    @(negedge i_clock);
    chk("idle_deselected_miso", o_miso, 1);
    i_nss = 1'b0;
    #1;
    chk("ready_ack", o_miso, 0);
    @(negedge i_clock);

    run_frame("div_100_7",   16'd100,  16'd7,      OP_DIV, 16'h000E, STD_START, 1'b0);
    run_frame("rem_100_7",   16'd100,  16'd7,      OP_REM, 16'h0002, STD_START, 1'b0);
    run_frame("rem_ffff_1",  16'hFFFF, 16'h0001,   OP_REM, 16'h0000, STD_START, 1'b0);
    run_frame("div_1234_0",  16'h1234, 16'h0000,   OP_DIV, 16'hFFFF, FAST_START, 1'b0);
    run_frame("rem_1234_0",  16'h1234, 16'h0000,   OP_REM, 16'h1234, FAST_START, 1'b0);
    run_frame("div_abcd_123", 16'hABCD, 16'h0123,  OP_DIV, 16'h0097, STD_START, 1'b0);
    run_frame("rem_abcd_123", 16'hABCD, 16'h0123,  OP_REM, 16'h0028, STD_START, 1'b0);
    run_frame("div_5_9",     16'd5,    16'd9,      OP_DIV, 16'h0000, FAST_START, 1'b0);
    run_frame("rem_5_9",     16'd5,    16'd9,      OP_REM, 16'h0005, FAST_START, 1'b0);
    run_frame("op_000",      16'd100,  16'd7,      3'b000, 16'h0000, STD_START, 1'b0);
    run_frame("div_9_3",     16'd9,    16'd3,      OP_DIV, 16'h0003, STD_START, 1'b0);

    // Deselect coinciding with the last result bit
    run_frame("div_ffff_ff_nss_last", 16'hFFFF, 16'h00FF, OP_DIV, 16'h0101, STD_START, 1'b1);
    i_nss = 1'b0;
    step();

    // Abort at cycle 20, mid-request
    vec = {16'd50, 16'd5, OP_DIV};
    i_mosi = 1'b1;
    e = -1;
    step();
    for (int i = 0; i < 19; i++) begin
      i_mosi = vec[i];
      step();
    end
    i_nss  = 1'b1;
    i_mosi = 1'b0;
    step();
    chk("abort_pulse", o_abort, 1);
    chk("abort_miso", o_miso, 1);
    chk("abort_busy", o_busy, 0);
    step();
    chk("abort_single_pulse", o_abort, 0);
    i_nss = 1'b0;
    step();
    run_frame("div_50_5_after_abort", 16'd50, 16'd5, OP_DIV, 16'h000A, STD_START, 1'b0);

    // Reset asserted at cycle 40, inside the divider loop
    vec = {16'd1000, 16'd33, OP_DIV};
    i_mosi = 1'b1;
    e = -1;
    step();
    for (int i = 0; i < 35; i++) begin
      i_mosi = vec[i];
      step();
    end
    i_mosi = 1'b0;
    repeat (5) step();
    chk("rstmid_cycle", e, 40);
    chk("rstmid_busy_before", o_busy, 1);
    i_reset = 1'b0;
    #1;
    chk("rstmid_miso", o_miso, 1);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_abort", o_abort, 0);
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    ones = 0;
    repeat (30) begin
      step();
      if (o_miso !== 1'b0) ones++;
    end
    chk("rstmid_no_response", ones, 0);
    run_frame("div_1000_33_after_reset", 16'd1000, 16'd33, OP_DIV, 16'h001E, STD_START, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_div_slave.md
# spi_div_slave

SPI responder that executes unsigned 16-bit division (quotient or remainder) for the processor's SPI master. It sits on the shared SPI bus beside the ALU, multiplier and shifter slaves. It has its own `nss` select line and uses the same framing: start bit, LSB-first `{opa, opb, op_code}` request, and a start-bit-framed LSB-first result. Internally it runs an iterative restoring divider, one quotient bit per cycle.

## Interface
- `WIDTH`, 16: operand and result width.
- `OP_W`, 3: op-code field width.
- `OP_DIV`, 3'b110: op code that returns the quotient.
- `OP_REM`, 3'b111: op code that returns the remainder.
- `i_clock`, in, 1: single clock. It is also the SPI `sclk`, so all SPI signals are sampled on its rising edge.
- `i_reset`, in, 1: reset, asynchronous and active-low.
- `i_nss`, in, 1: slave select, active-low.
- `i_mosi`, in, 1: master-to-slave data.
- `o_miso`, out, 1: slave-to-master data.
- `o_busy`, out, 1: high in any state other than IDLE.
- `o_abort`, out, 1: one-cycle pulse when a frame is aborted by `i_nss` rising.

## Operation
- **States:** IDLE, RECV, CALC, RESP_START, RESP.
- **IDLE:**
  - `o_miso` = 1 if `i_nss` = 1, else 0. The 0 is the ready acknowledge.
  - Moves to RECV when `i_nss` = 0 and `i_mosi` = 1 (start bit). The bit counter is cleared.
- **RECV:**
  - Samples `i_mosi` for `2*WIDTH+OP_W` = 35 cycles into a shift register, LSB first.
  - Bit 0 is `op[0]`. Bits 3..18 are `opb` (divisor). Bits 19..34 are `opa` (dividend).
  - `o_miso` = 0 throughout.
  - After the last bit, moves to CALC.
- **CALC:**
  - Restoring divider, `WIDTH` iterations, one per cycle.
  - Partial remainder is `WIDTH+1` bits wide; subtraction is unsigned.
  - `o_miso` = 0 throughout.
  - After the last iteration, the result is latched and the state moves to RESP_START.
- **Result selection:**
  - `op == OP_DIV` returns the quotient.
  - `op == OP_REM` returns the remainder.
  - Any other op returns 0. The full transaction still runs, so the master never hangs.
- **Divide by zero:** quotient = all ones (16'hFFFF); remainder = `opa`.
- **RESP_START:** `o_miso` = 1 for exactly one cycle, then the state moves to RESP.
- **RESP:** `o_miso` = `result[k]` for k = 0..15, one bit per cycle, then the state returns to IDLE.
- **Abort:** if `i_nss` rises in RECV, CALC, RESP_START or RESP:
  - go to IDLE on the next edge;
  - `o_abort` pulses high for 1 cycle;
  - partial data is discarded;
  - `o_miso` = 1.
- **Back-to-back frames:** after RESP, a new start bit is accepted from IDLE on the very next cycle.

## Timing
- **Reset values:** state IDLE, `o_miso` = 1, `o_busy` = 0, `o_abort` = 0, all counters and shift registers 0.
- **Reset mid-operation:** outputs return to the reset values immediately (asynchronously), and no response is emitted.
- **Cycle numbering:** cycle 0 is the edge that samples the start bit.
  - Request bits are sampled at cycles 1..35.
  - CALC occupies cycles 36..51.
  - `o_miso` start bit is driven during cycle 52.
  - Result bits are driven during cycles 53..68.
  - IDLE is reached at cycle 69.
- **Latency:** start bit to first result bit is 53 cycles. Total frame is 69 cycles.
- **Master handshake compatibility:**
  - The master leaves its send state when it sees `miso` = 0 together with `mosi` = 1.
  - It leaves its receive-wait state when it sees `miso` = 1 together with `mosi` = 0.
  - The slave therefore holds `o_miso` low continuously from IDLE-selected through CALC.
- **Start-bit ambiguity:** `i_mosi` is ignored outside IDLE. A `mosi` = 1 during CALC or RESP is not a start bit.
- **Simultaneous events:** `i_nss` rising on the same cycle as the last RESP bit is treated as normal completion, not an abort, and `o_abort` stays 0.

## Configuration
- **`SPI_DIV_FAST_EXIT_EN` defined:** CALC is skipped when `opb == 0` or `opa < opb`. The result is computed directly:
  - quotient 0 and remainder `opa`, or
  - the divide-by-zero values.
  - RESP_START then follows RECV after 1 cycle, and total frame length is 54 cycles.
- **`SPI_DIV_FAST_EXIT_EN` undefined:** CALC always takes `WIDTH` cycles. Results are identical either way.

## Test plan
- **Quotient:** `opa`=100, `opb`=7, `op`=`OP_DIV`.
  - `o_miso` start bit at cycle 52.
  - Serial result is 14 (16'h000E), LSB first.
  - `o_busy` falls at cycle 69.
- **Remainder:** same operands with `op`=`OP_REM` returns 2. Then `opa`=16'hFFFF, `opb`=16'h0001 with `OP_REM` returns 0.
- **Divide by zero:** `opa`=16'h1234, `opb`=0.
  - `OP_DIV` returns 16'hFFFF.
  - `OP_REM` returns 16'h1234.
  - With `SPI_DIV_FAST_EXIT_EN`, the start bit arrives at cycle 37 instead of 52.
- **Unsupported op and back-to-back:** `op`=3'b000 returns 16'h0000 at the standard timing. An immediately following `OP_DIV` frame (9/3) returns 3.
- **Abort:** `i_nss` raised at cycle 20 (mid-RECV).
  - `o_abort` pulses once and `o_miso` = 1.
  - A following `OP_DIV` frame with `opa`=50, `opb`=5 returns 10 uncorrupted.
- **Reset mid-operation:** `i_reset` asserted low during CALC (cycle 40).
  - Immediately: `o_miso` = 1, `o_busy` = 0, and no start bit follows.
  - After release, a fresh frame completes correctly.
